clint_arbiter: RTL
==================

Name: clint_arbiter

Overview:
Two-port arbiter and sequencer in front of the CLINT register port (msip / mtimecmp / mtime). It shares the single CLINT req/we/addr/data interface between the core load-store port (m0) and the debug/host port (m1) using round-robin arbitration. It also provides each requester a coherent 64-bit mtime read: reading the mtime low word snapshots the matching high word. It sits between the bus decoder and the clint instance; the clint interrupt outputs bypass this block.

Parameters:
DW, 32, data/address width (`DATA_WIDTH)
TIME_LO, 16'hBFF8, mtime low-word offset (addr[15:0])
TIME_HI, 16'hBFFC, mtime high-word offset (addr[15:0])

Ports:
clk_i  in  1  clock
rst_i  in  1  reset: asynchronous, active-high
m0_req_i / m1_req_i  in  1  access request; held until grant
m0_we_i / m1_we_i  in  1  1 = write, 0 = read
m0_addr_i / m1_addr_i  in  DW  byte address
m0_data_i / m1_data_i  in  DW  write data
m0_gnt_o / m1_gnt_o  out  1  one-cycle accept pulse
m0_rvalid_o / m1_rvalid_o  out  1  one-cycle completion pulse (reads and writes)
m0_rdata_o / m1_rdata_o  out  DW  read data, valid with rvalid, held until next completion for that port
clint_req_o  out  1  CLINT chip enable
clint_we_o  out  1  CLINT write enable
clint_addr_o  out  DW  CLINT address
clint_data_o  out  DW  CLINT write data
clint_data_i  in  DW  CLINT combinational read data

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, rr pointer=0 (m0 preferred).
  - All outputs 0, both snapshot registers and snap_valid[1:0] cleared.
  - Reset mid-transaction aborts it; no rvalid is issued.
- FSM states and transitions:
  - IDLE:
    - If any req is high, pick the winner. Both requesting: the port not served last wins (rr pointer). One requesting: that port wins.
    - Winner's gnt_o is driven combinationally in this same cycle.
    - Latch winner id, we, addr, data. Go to ACCESS.
    - A req dropped before gnt is legal and produces no transaction.
  - ACCESS:
    - Drive clint_req_o=1, clint_we_o=latched we, clint_addr_o and clint_data_o from the latch for exactly one cycle.
    - Register clint_data_i into the winner's rdata on reads.
    - Latched read with addr[15:0]==TIME_LO: record lo_ff = (clint_data_i==32'hFFFF_FFFF), go to SNAP. Otherwise go to RESP.
  - SNAP:
    - Drive clint_req_o=1, clint_we_o=0, addr={addr[31:16],TIME_HI}.
    - Store snap_hi[winner] = clint_data_i - lo_ff. This corrects for the mtime carry that lands between cycles.
    - Set snap_valid[winner]=1. Go to RESP.
  - RESP: pulse winner's rvalid_o, set rr pointer = winner, return to IDLE.
- Snapshot use:
  - Read of TIME_HI by port N with snap_valid[N]=1 returns snap_hi[N] instead of clint_data_i, then clears snap_valid[N].
  - Any other completed access by port N clears snap_valid[N]. Port N never affects port M's snapshot.
- Latency: gnt at cycle T; rvalid at T+2 (plain access) or T+3 (TIME_LO read). New grant no earlier than T+3 / T+4.
- clint_req_o, clint_we_o are 0 outside ACCESS/SNAP.
- Writes are passed through unmodified, including writes to mtime offsets (ignored downstream).
- Only addr[15:0] is decoded here. The upper address is forwarded.

Decomposition:
- Shared package/defines: DW (`DATA_WIDTH), CLINT offsets (MSIP 16'h0, MTIMECMP 16'h4000/16'h4004, TIME_LO/TIME_HI), FSM state encodings (IDLE, ACCESS, SNAP, RESP), `RESET_ENABLE.
- One natural sub-module: rr_arb2, a two-requester round-robin picker (req[1:0], last -> gnt[1:0]), purely combinational.

Test Plan:
1. Reset asserted mid-ACCESS: all outputs 0 within the reset cycle, no rvalid afterwards, next lone m1 request granted normally.
2. m0 and m1 request simultaneously from reset: m0 granted at T, m1 granted after m0's rvalid. Repeat: m1 wins the next tie, then m0 (alternation).
3. m0 writes 32'h0000_0100 to 0x4000, then reads 0x4000: rvalid at T+2 with rdata=32'h0000_0100; clint_we_o high for exactly one cycle.
4. Preload CLINT mtime=64'h0000_0005_FFFF_FFFF at ACCESS. m1 reads TIME_LO then TIME_HI: rdata 32'hFFFF_FFFF then 32'h0000_0005, not 6.
5. m0 reads TIME_LO, m1 reads TIME_HI, m0 reads TIME_HI: m1 gets live high word; m0 gets its snapshot. A second m0 TIME_HI read gets the live value.
6. m1 reads TIME_LO, then msip (0x0), then TIME_HI: snapshot cleared by the msip access, TIME_HI returns live value.

Source files
------------

// File: rtl/clint_arbiter_pkg.sv
// Shared widths, CLINT register offsets and sequencer states for the
// CLINT port arbiter.
package clint_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 16;

  localparam logic [OFF_W-1:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [OFF_W-1:0] OFF_TIME_HI = 16'hBFFC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SNAP   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Request as presented on the shared CLINT register port.
  typedef struct packed {
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } clint_bus_t;

endpackage

// File: rtl/clint_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the port not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/clint_arbiter.sv
// Shares the CLINT register port between the core (m0) and debug (m1) ports,
// and gives each port a carry-coherent 64-bit mtime read via a private snapshot.
module clint_arbiter
  import clint_arbiter_pkg::*;
#(
  parameter logic [OFF_W-1:0] TIME_LO = OFF_TIME_LO,
  parameter logic [OFF_W-1:0] TIME_HI = OFF_TIME_HI
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [DATA_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [DATA_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              clint_req_o,
  output logic              clint_we_o,
  output logic [DATA_W-1:0] clint_addr_o,
  output logic [DATA_W-1:0] clint_data_o,
  input  logic [DATA_W-1:0] clint_data_i
);

  localparam int unsigned DW = DATA_W;

  state_e           state;
  clint_bus_t       bus;
  logic             win;
  logic             lo_ff;
  logic             last;
  logic [1:0]       snap_valid;
  logic [1:0]       rvalid;
  logic [DW-1:0]    snap_hi [2];
  logic [DW-1:0]    rdata   [2];
  logic [1:0]       pick;
  logic [1:0]       gnt_c;
  logic [OFF_W-1:0] off;

  rr_arb2 u_rr (
    .req  ({m1_req_i, m0_req_i}),
    .last (last),
    .gnt  (pick)
  );

  // Accept is combinational so the requester sees it in its request cycle.
  assign gnt_c = (state == ST_IDLE && !rst_i) ? pick : 2'b00;
  assign off   = bus.addr[OFF_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      bus        <= '0;
      win        <= 1'b0;
      lo_ff      <= 1'b0;
      // Marks m1 as last served so m0 wins the first tie.
      last       <= 1'b1;
      snap_valid <= 2'b00;
      rvalid     <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        snap_hi[i] <= '0;
        rdata[i]   <= '0;
      end
    end else begin
      rvalid <= 2'b00;
      unique case (state)
        ST_IDLE: begin
          if (|pick) begin
            win      <= pick[1];
            bus.req  <= 1'b1;
            bus.we   <= pick[1] ? m1_we_i   : m0_we_i;
            bus.addr <= pick[1] ? m1_addr_i : m0_addr_i;
            bus.data <= pick[1] ? m1_data_i : m0_data_i;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Every completed access consumes the port's snapshot; a TIME_LO
          // read re-arms it in SNAP.
          snap_valid[win] <= 1'b0;
          if (!bus.we) begin
            rdata[win] <= (off == TIME_HI && snap_valid[win]) ? snap_hi[win]
                                                               : clint_data_i;
          end
          if (!bus.we && off == TIME_LO) begin
            lo_ff                <= &clint_data_i;
            bus.addr[OFF_W-1:0]  <= TIME_HI;
            state                <= ST_SNAP;
          end else begin
            bus.req     <= 1'b0;
            bus.we      <= 1'b0;
            rvalid[win] <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_SNAP: begin
          // A low word of all ones means mtime carried into the high word
          // between ACCESS and SNAP; undo that carry.
          snap_hi[win]    <= clint_data_i - DW'(lo_ff);
          snap_valid[win] <= 1'b1;
          bus.req         <= 1'b0;
          rvalid[win]     <= 1'b1;
          state           <= ST_RESP;
        end
        ST_RESP: begin
          last  <= win;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m0_gnt_o     = gnt_c[0];
  assign m1_gnt_o     = gnt_c[1];
  assign m0_rvalid_o  = rvalid[0];
  assign m1_rvalid_o  = rvalid[1];
  assign m0_rdata_o   = rdata[0];
  assign m1_rdata_o   = rdata[1];
  assign clint_req_o  = bus.req;
  assign clint_we_o   = bus.we;
  assign clint_addr_o = bus.addr;
  assign clint_data_o = bus.data;

endmodule
